// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers {pc, pc+4, instr} into the IF/ID holding register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc4_q;
    logic [31:0] if_instr_q;
    logic        if_valid_q;
    logic        halted_q;
    logic [31:0] fetch_count_q;

    logic [31:0] pc_inc_d;
    logic [31:0] redirect_pc_d;

    assign pc_inc_d      = pc_q + 32'd4;
    assign redirect_pc_d = {redirect_pc[31:2], 2'b00};

    // Handshake: redirect_valid has no ready; a redirect is consumed on any
    // rising edge outside HALT and always wins over stall in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            if_pc_q       <= 32'd0;
            if_pc4_q      <= 32'd0;
            if_instr_q    <= NOP_WORD;
            if_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    if (redirect_valid) begin
                        pc_q <= redirect_pc_d;
                    end
                end
                RUN: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_pc_d;
                        if_instr_q <= NOP_WORD;
                        if_valid_q <= 1'b0;
                    end else if (!stall) begin
                        if (imem_rdata == HALT_WORD) begin
                            state_q    <= HALT;
                            halted_q   <= 1'b1;
                            if_valid_q <= 1'b0;
                            if_instr_q <= NOP_WORD;
                        end else begin
                            if_pc_q       <= pc_q;
                            if_pc4_q      <= pc_inc_d;
                            if_instr_q    <= imem_rdata;
                            if_valid_q    <= 1'b1;
                            pc_q          <= pc_inc_d;
                            fetch_count_q <= fetch_count_q + 32'd1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign if_pc       = if_pc_q;
    assign if_pc4      = if_pc4_q;
    assign if_instr    = if_instr_q;
    assign if_valid    = if_valid_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect
// traffic checked against a rule-level model and an expected-instruction queue.
module tb_fetch_stage;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_W  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic [1:0]  dbg_state;

    logic [31:0] mem [256];
    assign imem_rdata = mem[imem_addr[9:2]];

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_pc         (if_pc),
        .if_pc4        (if_pc4),
        .if_instr      (if_instr),
        .if_valid      (if_valid),
        .halted        (halted),
        .fetch_count   (fetch_count),
        .dbg_state_o   (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: phase 0=boot,1=run,2=halt
    int          m_phase;
    logic [31:0] m_pc, m_if_pc, m_if_pc4, m_if_instr, m_count;
    logic        m_valid, m_halted;
    logic [31:0] exp_q[$];
    logic [31:0] seen_count;

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        return mem[idx];
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pc = 32'd0; m_if_pc = 32'd0; m_if_pc4 = 32'd0;
        m_if_instr = NOP_W; m_valid = 1'b0; m_halted = 1'b0; m_count = 32'd0;
        exp_q.delete();
        seen_count = 32'd0;
    endtask

    task automatic model_edge(input logic s, input logic rv, input logic [31:0] rpc);
        logic [31:0] w;
        w = mem_at(m_pc);
        if (m_phase == 2) begin
            // frozen
        end else if (m_phase == 0) begin
            if (rv) m_pc = rpc & ~32'd3;
            m_phase = 1;
        end else if (rv) begin
            m_pc = rpc & ~32'd3; m_if_instr = NOP_W; m_valid = 1'b0;
        end else if (s) begin
            // hold
        end else if (w == HALT_W) begin
            m_phase = 2; m_halted = 1'b1; m_valid = 1'b0; m_if_instr = NOP_W;
        end else begin
            m_if_pc = m_pc; m_if_pc4 = m_pc + 32'd4; m_if_instr = w; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
            exp_q.push_back(w);
        end
    endtask

    task automatic check_all();
        check("imem_addr", imem_addr, m_pc);
        check("if_pc", if_pc, m_if_pc);
        check("if_pc4", if_pc4, m_if_pc4);
        check("if_instr", if_instr, m_if_instr);
        check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        check("halted", {31'd0, halted}, {31'd0, m_halted});
        check("fetch_count", fetch_count, m_count);
        check("state", {30'd0, dbg_state}, m_phase[31:0]);
    endtask

    // scoreboard: each count increment must deliver the oldest expected word
    task automatic scoreboard();
        if (fetch_count != seen_count) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", fetch_count, seen_count);
            end else begin
                check("sb_instr", if_instr, exp_q.pop_front());
            end
            seen_count = fetch_count;
        end
    endtask

    task automatic step(input logic s, input logic rv, input logic [31:0] rpc);
        stall = s; redirect_valid = rv; redirect_pc = rpc;
        model_edge(s, rv, rpc);
        @(posedge clk);
        #1;
        check_all();
        scoreboard();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom();
            if (mem[i] == HALT_W) mem[i] = 32'h1234_5678;
        end
        mem[0] = 32'h2008_0005; mem[1] = 32'h2009_0003;
        mem[2] = 32'h0109_5020; mem[3] = 32'hAC0A_0000;

        do_reset();

        // clean fetch of the first words
        repeat (4) step(1'b0, 1'b0, 32'd0);
        check("t1_if_pc", if_pc, 32'd8);
        check("t1_count", fetch_count, 32'd3);

        // two stalled cycles then resume
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("t2_pc_hold", imem_addr, 32'd12);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // redirect wins over stall, one bubble
        step(1'b1, 1'b1, 32'h40);
        check("t3_pc", imem_addr, 32'h40);
        check("t3_bubble", {31'd0, if_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("t3_word", if_instr, mem[16]);

        // alignment and wraparound
        step(1'b0, 1'b1, 32'h43);
        check("t4_align", imem_addr, 32'h40);
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0);
        check("t4_pc4_wrap", if_pc4, 32'd0);
        check("t4_pc_wrap", imem_addr, 32'd0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic s, rv;
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 6) == 0);
            step(s, rv, $urandom());
        end

        // halt sentinel at 0x10
        mem[4] = HALT_W;
        step(1'b0, 1'b1, 32'h10);
        step(1'b0, 1'b0, 32'd0);
        check("t5_halted", {31'd0, halted}, 32'd1);
        check("t5_pc", imem_addr, 32'h10);
        for (int i = 0; i < 6; i++) begin
            step(1'(i % 2), 1'(i % 3 != 0), $urandom());
        end
        do_reset();
        check("t5_reset_halt", {31'd0, halted}, 32'd0);
        check("t5_reset_pc", imem_addr, 32'd0);
        mem[4] = 32'h2000_0004;

        // asynchronous reset between edges, with a redirect pending
        repeat (5) step(1'b0, 1'b0, 32'd0);
        #3;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0; redirect_valid = 1'b0;
        repeat (4) step(1'b0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
